mem_reader: RTL
===============

# mem_reader

Streams a contiguous range of a synchronous-read memory (data or instruction RAM) out on a valid/ready word stream. It is the read-side counterpart of the memory write path: the same RAM that the write path fills through `wrEn`/`dataIn`-style ports is drained by this block for result dump, core-to-core transfer or the UART transmit path. The block hides the RAM's one-cycle read latency behind a 2-entry output buffer and sustains one word per clock while `dataReady` stays high.

## Interface
- `ADDR_WIDTH`, 12: RAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, 12: word width.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a transfer; sampled only in IDLE.
- `startAddr` in ADDR_WIDTH: first address; sampled with `start`.
- `endAddr` in ADDR_WIDTH: last address, inclusive; sampled with `start`.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse after the last word is accepted.
- `memRdEn` out 1: RAM read strobe.
- `memAddr` out ADDR_WIDTH: RAM read address.
- `memDataIn` in DATA_WIDTH: RAM read data, valid in the cycle after `memRdEn`.
- `dataOut` out DATA_WIDTH: stream word.
- `dataValid` out 1: `dataOut` is valid.
- `dataReady` in 1: consumer accepts the word when `dataValid && dataReady` at posedge.

## Operation
- Word count N = ((endAddr − startAddr) mod 2^ADDR_WIDTH) + 1, range 1 to 2^ADDR_WIDTH. `endAddr < startAddr` means the range wraps through the maximum address to 0.
- FSM `IDLE → READ → DRAIN → FINISH → IDLE`.
  - IDLE: on `start`, latch the address, set the remaining-issue count to N, and go to READ.
  - READ: issue reads. When the last read issues, go to DRAIN.
  - DRAIN: wait until the in-flight read has landed and the buffer is empty. Then go to FINISH.
  - FINISH: `done`=1 for one cycle, then return to IDLE.
- Read issue rule: in READ, `memRdEn`=1 iff (count + inflight − pop) < 2.
  - `count` is buffer occupancy. `inflight` is 1 if `memRdEn` was high last cycle. `pop` = `dataValid && dataReady`.
  - On each issue, `memAddr` increments modulo 2^ADDR_WIDTH.
- In the cycle after `memRdEn`, `memDataIn` is pushed into the buffer unconditionally. The credit rule guarantees there is space, so no word is ever dropped.
- Words leave the block in address order.
- `dataValid` = buffer non-empty. While `dataValid && !dataReady`, `dataOut` holds stable.
- `start` is ignored while `busy`.
- `busy` = state != IDLE && state != FINISH.
- Reset values: `busy`=0, `done`=0, `memRdEn`=0, `memAddr`=0, `dataValid`=0, `dataOut`=0, state IDLE, buffer empty.
- Reset mid-transfer aborts immediately. Buffered and in-flight words are discarded and no `done` pulse is produced.

## Timing
- With `start` high in cycle 0:
  - cycle 1: `memRdEn`=1, `memAddr`=startAddr, `busy`=1.
  - cycle 2: `memDataIn` carries word 0.
  - cycle 3: `dataValid`=1, `dataOut`=word 0.
- With `dataReady` held high, word k is presented in cycle 3+k.
- For a transfer with N words and no stalls:
  - last handshake in cycle N+2;
  - `done`=1 and `busy`=0 in cycle N+3;
  - `start` is accepted again from cycle N+4.
- When `dataReady` drops, at most 2 words are held in the buffer and issue stops. When `dataReady` rises again, the first word is accepted in that same cycle and a read reissues in that cycle.
- Push and pop in the same cycle leave occupancy unchanged.

## Structure
- Package `mem_reader_pkg` holds:
  - the state enum `mem_reader_state_t` with values IDLE, READ, DRAIN, FINISH;
  - `BUF_DEPTH = 2`.
- Sub-module `skid_fifo`: a 2-entry FIFO parameterised by DATA_WIDTH, with ports `push`, `pop`, `dataIn`, `dataOut`, `empty` and `count`, using the same async active-high `rst`.
- The top level holds the FSM, the address counter, the remaining-issue counter (ADDR_WIDTH+1 bits), the `inflight` flag and the credit logic.

## Test plan
- RAM preloaded with mem[a] = a + 100. Run start 5 → end 8 with `dataReady`=1:
  - outputs 105, 106, 107, 108 in cycles 3–6;
  - `done` in cycle 7.
- Wrap-around with ADDR_WIDTH=12, start 4094 → end 1:
  - words from addresses 4094, 4095, 0, 1 in that order;
  - N=4.
- Backpressure during start 0 → 9: hold `dataReady`=0 for 5 cycles mid-stream.
  - `dataOut` stays stable and `memRdEn` stays 0 after 2 words are buffered;
  - no loss or duplication;
  - 10 words total.
- Single word, start = end = 7: exactly one word, 107, then `done`.
- `start` pulsed while `busy`: ignored.
- Reset mid-transfer: assert `rst` during cycle 4 of a 10-word run.
  - all outputs return to their reset values and `done` never pulses;
  - a new start 2 → 3 afterwards yields exactly 102, 103.

Source files
------------

// File: rtl/mem_reader_pkg.sv
// ============================================================
// Package : mem_reader_pkg
// Shared FSM state type and output-buffer sizing for mem_reader.
// Rev     : 1.0
// ============================================================
`default_nettype none

package mem_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } mem_reader_state_t;

  localparam int BUF_DEPTH = 2;
  localparam int CNT_WIDTH = $clog2(BUF_DEPTH + 1);
  localparam int PTR_WIDTH = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [CNT_WIDTH-1:0] BUF_FULL = CNT_WIDTH'(BUF_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

endpackage

`default_nettype wire

// File: rtl/mem_reader_if.sv
// ============================================================
// Interface : mem_reader_if
// Control, RAM read port and output stream of mem_reader.
// Rev       : 1.0
// ============================================================
`default_nettype none

interface mem_reader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) ();

  logic                  start;
  logic [ADDR_WIDTH-1:0] startAddr;
  logic [ADDR_WIDTH-1:0] endAddr;
  logic                  busy;
  logic                  done;

  logic                  memRdEn;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memDataIn;

  logic [DATA_WIDTH-1:0] dataOut;
  logic                  dataValid;
  logic                  dataReady;

  // master: the reader itself; slave: controller, RAM and stream consumer
  modport master (
    input  start, startAddr, endAddr, memDataIn, dataReady,
    output busy, done, memRdEn, memAddr, dataOut, dataValid
  );

  modport slave (
    output start, startAddr, endAddr, memDataIn, dataReady,
    input  busy, done, memRdEn, memAddr, dataOut, dataValid
  );

endinterface

`default_nettype wire

// File: rtl/mem_reader_skid_fifo.sv
// ============================================================
// Module : skid_fifo
// Two-entry output buffer absorbing the RAM read latency.
// Rev    : 1.0
// ============================================================
`default_nettype none

module skid_fifo
  import mem_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  count
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr_q;
  logic [PTR_WIDTH-1:0]  wr_ptr_q;
  logic [CNT_WIDTH-1:0]  count_q;

  logic w_do_pop;
  logic w_do_push;

  // A push into a full buffer is only legal when the same cycle frees a slot
  assign w_do_pop  = pop && (count_q != '0);
  assign w_do_push = push && ((count_q != BUF_FULL) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_ptr_q] <= dataIn;
        wr_ptr_q        <= wr_ptr_q + PTR_WIDTH'(1);
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dataOut = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

`default_nettype wire

// File: rtl/mem_reader.sv
// ============================================================
// Module : mem_reader
// Streams a contiguous RAM address range onto a valid/ready stream.
// Rev    : 1.0
// ============================================================
`default_nettype none

module mem_reader
  import mem_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input  logic         clk,
  input  logic         rst,
  mem_reader_if.master bus
);

  localparam logic [CNT_WIDTH:0]  CRED_LIMIT = (CNT_WIDTH + 1)'(BUF_DEPTH);
  localparam logic [ADDR_WIDTH:0] REM_ONE    = (ADDR_WIDTH + 1)'(1);

  mem_reader_state_t     state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  inflight_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  w_fifo_empty;
  logic [CNT_WIDTH-1:0]  w_fifo_count;
  logic [DATA_WIDTH-1:0] w_fifo_dout;
  logic                  w_pop;
  logic [CNT_WIDTH:0]    w_credit;
  logic                  w_issue;
  logic                  w_last_issue;
  logic                  w_drain_done;
  logic [ADDR_WIDTH:0]   w_count_n;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH:0]   remaining_d;

  assign w_pop = !w_fifo_empty && bus.dataReady;

  // Occupancy the buffer will reach once the in-flight read lands; a new read
  // may only go out while that stays below the buffer depth.
  assign w_credit = {1'b0, w_fifo_count}
                  + {{CNT_WIDTH{1'b0}}, inflight_q}
                  - {{CNT_WIDTH{1'b0}}, w_pop};

  assign w_issue      = (state_q == READ) && (w_credit < CRED_LIMIT);
  assign w_last_issue = w_issue && (remaining_q == REM_ONE);

  // The buffer empties this cycle when nothing is in flight and the only
  // remaining word (if any) is being accepted now.
  assign w_drain_done = !inflight_q && (w_fifo_count == CNT_WIDTH'(w_pop));

  // Full-range transfers (end = start - 1) need the extra count bit
  assign w_count_n   = {1'b0, bus.endAddr - bus.startAddr} + REM_ONE;
  assign addr_d      = addr_q + ADDR_WIDTH'(1);
  assign remaining_d = remaining_q - REM_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      inflight_q <= w_issue;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            addr_q      <= bus.startAddr;
            remaining_q <= w_count_n;
            busy_q      <= 1'b1;
            state_q     <= READ;
          end
        end
        READ: begin
          if (w_issue) begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            if (w_last_issue) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_drain_done) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (inflight_q),
    .pop     (w_pop),
    .dataIn  (bus.memDataIn),
    .dataOut (w_fifo_dout),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  assign bus.memRdEn   = w_issue;
  assign bus.memAddr   = addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dataValid = !w_fifo_empty;
  assign bus.dataOut   = w_fifo_dout;

endmodule

`default_nettype wire
